// File: rtl/prom_seq_pkg.sv
// Shared opcodes, state encoding and result codes for the PROM write sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package prom_seq_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [2:0] ENGINE_IDLE = 3'd0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN,
        ST_PROG,
        ST_ISSUE_WAIT,
        ST_GAP,
        ST_POLL,
        ST_CHECK,
`ifdef PROM_SEQ_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_WEL     = 2'd2
    } seq_err_e;

    // Engine command quadlets carry the opcode in the top byte.
    function automatic logic [31:0] op_quadlet(input logic [7:0] op);
        return {op, 24'h00_0000};
    endfunction

endpackage

// File: rtl/prom_poll_timer.sv
// Poll spacing timer: 16-bit down-counter loaded with GAP, one-cycle expire pulse.
// Latency: expire asserts GAP cycles after the load cycle.
// Backpressure: none; a new load restarts the count.
module prom_poll_timer #(
    parameter int unsigned GAP = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [15:0] cnt_q, cnt_d;
    logic        active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        expire   = active_q && (cnt_q == 16'd1);
        if (load) begin
            cnt_d    = GAP[15:0];
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == 16'd1) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 16'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/prom_write_sequencer.sv
// WREN/program/RDSR-poll sequencer plus host arbitration for the 25AA128 engine.
// Latency: host commands forward same cycle when idle; otherwise one-deep holding register.
// Backpressure: waits on engine state [2:0]==0 before every strobe; PROM_SEQ_VERIFY_EN adds a WEL check.
module prom_write_sequencer
    import prom_seq_pkg::*;
#(
    parameter int unsigned POLL_GAP = 256,
    parameter int unsigned POLL_MAX = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_start,
    input  logic [31:0] job_cmd,
    input  logic [31:0] host_cmd,
    input  logic        host_wen,
    input  logic [31:0] prom_status,
    input  logic [31:0] prom_result,
    output logic [31:0] prom_cmd,
    output logic        prom_reg_wen,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [1:0]  seq_err,
    output logic [15:0] poll_count,
    output logic        host_pending,
    output logic        host_overrun
);

    seq_state_e  state_q, state_d;
    seq_state_e  ret_q, ret_d;
    logic [31:0] job_cmd_q, job_cmd_d;
    logic [31:0] prom_cmd_q, prom_cmd_d;
    logic        strobe_q;
    logic        seq_busy_q, seq_busy_d;
    logic [1:0]  seq_err_q, seq_err_d;
    logic [15:0] poll_count_q, poll_count_d;
    logic [31:0] hold_q, hold_d;
    logic        host_pending_q, host_pending_d;
    logic        host_overrun_q, host_overrun_d;
`ifdef PROM_SEQ_VERIFY_EN
    logic        verify_armed_q, verify_armed_d;
    logic        verify_sent_q, verify_sent_d;
`endif

    logic        issue;
    logic [31:0] issue_cmd;
    logic        done_pulse;
    logic        host_vld;
    logic        host_fwd;
    logic        pend_issue;
    logic        timer_load;
    logic        timer_expire;
    logic        eng_idle;
    logic        unused_ok;

    // The engine only leaves idle one clock after a strobe, so the cycle after
    // any strobe is never treated as idle.
    assign eng_idle  = (prom_status[2:0] == ENGINE_IDLE) && !strobe_q;
    assign host_vld  = host_wen && (host_cmd[31:24] != 8'h00);
    assign unused_ok = ^{prom_status[31:3], prom_result[31:1]};

    prom_poll_timer #(
        .GAP (POLL_GAP)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        job_cmd_d      = job_cmd_q;
        seq_busy_d     = seq_busy_q;
        seq_err_d      = seq_err_q;
        poll_count_d   = poll_count_q;
        hold_d         = hold_q;
        host_pending_d = host_pending_q;
        host_overrun_d = host_overrun_q;
`ifdef PROM_SEQ_VERIFY_EN
        verify_armed_d = verify_armed_q;
        verify_sent_d  = verify_sent_q;
`endif
        issue      = 1'b0;
        issue_cmd  = prom_cmd_q;
        done_pulse = 1'b0;
        host_fwd   = 1'b0;
        pend_issue = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host_pending_q) begin
                    if (eng_idle) begin
                        issue      = 1'b1;
                        issue_cmd  = hold_q;
                        pend_issue = 1'b1;
                    end
                end else if (host_vld && eng_idle) begin
                    issue     = 1'b1;
                    issue_cmd = host_cmd;
                    host_fwd  = 1'b1;
                end else if (job_start) begin
                    job_cmd_d      = job_cmd;
                    poll_count_d   = 16'd0;
                    seq_err_d      = ERR_OK;
                    host_overrun_d = 1'b0;
                    seq_busy_d     = 1'b1;
                    state_d        = ST_WREN;
                end
            end
            ST_WREN: begin
                if (eng_idle) begin
                    issue     = 1'b1;
                    issue_cmd = op_quadlet(OP_WREN);
                    ret_d     = ST_PROG;
                    state_d   = ST_ISSUE_WAIT;
                end
            end
            ST_PROG: begin
                if (eng_idle) begin
                    issue     = 1'b1;
                    issue_cmd = job_cmd_q;
                    ret_d     = ST_GAP;
                    state_d   = ST_ISSUE_WAIT;
                end
            end
            ST_ISSUE_WAIT: begin
                if (eng_idle) begin
                    state_d    = ret_q;
                    timer_load = (ret_q == ST_GAP);
                end
            end
            ST_GAP: begin
                if (timer_expire) begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                if (eng_idle) begin
                    issue     = 1'b1;
                    issue_cmd = op_quadlet(OP_RDSR);
                    if (poll_count_q != 16'hFFFF) begin
                        poll_count_d = poll_count_q + 16'd1;
                    end
                    ret_d   = ST_CHECK;
                    state_d = ST_ISSUE_WAIT;
                end
            end
            ST_CHECK: begin
                if (!prom_result[0]) begin
`ifdef PROM_SEQ_VERIFY_EN
                    state_d        = ST_VERIFY;
                    timer_load     = 1'b1;
                    verify_armed_d = 1'b0;
                    verify_sent_d  = 1'b0;
`else
                    state_d = ST_DONE;
`endif
                end else if (poll_count_q == POLL_MAX[15:0]) begin
                    seq_err_d = ERR_TIMEOUT;
                    state_d   = ST_DONE;
                end else begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                end
            end
`ifdef PROM_SEQ_VERIFY_EN
            ST_VERIFY: begin
                // Two passes: first wait out the gap and send RDSR, then return here to read WEL.
                if (verify_sent_q) begin
                    if (prom_result[1]) begin
                        seq_err_d = ERR_WEL;
                    end
                    state_d = ST_DONE;
                end else if ((verify_armed_q || timer_expire) && eng_idle) begin
                    issue         = 1'b1;
                    issue_cmd     = op_quadlet(OP_RDSR);
                    verify_sent_d = 1'b1;
                    ret_d         = ST_VERIFY;
                    state_d       = ST_ISSUE_WAIT;
                end else if (timer_expire) begin
                    verify_armed_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                done_pulse = 1'b1;
                seq_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pend_issue) begin
            host_pending_d = 1'b0;
        end
        // A command arriving while the held one is being issued simply refills the register.
        if (host_vld && !host_fwd) begin
            hold_d         = host_cmd;
            host_pending_d = 1'b1;
            if (host_pending_q && !pend_issue) begin
                host_overrun_d = 1'b1;
            end
        end

        prom_cmd_d = issue ? issue_cmd : prom_cmd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            ret_q          <= ST_IDLE;
            job_cmd_q      <= 32'd0;
            prom_cmd_q     <= 32'd0;
            strobe_q       <= 1'b0;
            seq_busy_q     <= 1'b0;
            seq_err_q      <= 2'd0;
            poll_count_q   <= 16'd0;
            hold_q         <= 32'd0;
            host_pending_q <= 1'b0;
            host_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            job_cmd_q      <= job_cmd_d;
            prom_cmd_q     <= prom_cmd_d;
            strobe_q       <= issue;
            seq_busy_q     <= seq_busy_d;
            seq_err_q      <= seq_err_d;
            poll_count_q   <= poll_count_d;
            hold_q         <= hold_d;
            host_pending_q <= host_pending_d;
            host_overrun_q <= host_overrun_d;
        end
    end

`ifdef PROM_SEQ_VERIFY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            verify_armed_q <= 1'b0;
            verify_sent_q  <= 1'b0;
        end else begin
            verify_armed_q <= verify_armed_d;
            verify_sent_q  <= verify_sent_d;
        end
    end
`endif

    assign prom_cmd     = prom_cmd_d;
    assign prom_reg_wen = issue;
    assign seq_busy     = seq_busy_q;
    assign seq_done     = done_pulse;
    assign seq_err      = seq_err_q;
    assign poll_count   = poll_count_q;
    assign host_pending = host_pending_q;
    assign host_overrun = host_overrun_q;

endmodule
